// File: rtl/aes_pkg.sv
// Shared AES types: default block geometry, word/state types and the AddRoundKey FSM encoding.
package aes_pkg;
    localparam int unsigned WORD_SIZE_DEF  = 8;
    localparam int unsigned ARRAY_SIZE_DEF = 16;

    typedef logic [WORD_SIZE_DEF-1:0]                word_t;
    typedef logic [WORD_SIZE_DEF*ARRAY_SIZE_DEF-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ark_fsm_t;
endpackage

// File: rtl/ark_lane_xor.sv
// Combinational XOR of LANES key words with LANES state words.
module ark_lane_xor #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned LANES     = 4
) (
    input  logic [WORD_SIZE*LANES-1:0] key,
    input  logic [WORD_SIZE*LANES-1:0] state,
    output logic [WORD_SIZE*LANES-1:0] result
);
    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            result[i*WORD_SIZE +: WORD_SIZE] = key[i*WORD_SIZE +: WORD_SIZE] ^ state[i*WORD_SIZE +: WORD_SIZE];
        end
    end
endmodule

// File: rtl/add_round_key_iter.sv
// Handshaked AES AddRoundKey: XORs LANES words per cycle over ARRAY_SIZE/LANES cycles.
// Define ARK_PARITY_EN to add the per-word parity_out port.
module add_round_key_iter #(
    parameter int unsigned WORD_SIZE  = aes_pkg::WORD_SIZE_DEF,
    parameter int unsigned ARRAY_SIZE = aes_pkg::ARRAY_SIZE_DEF,
    parameter int unsigned LANES      = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_SIZE*ARRAY_SIZE-1:0]  key,
    input  logic [WORD_SIZE*ARRAY_SIZE-1:0]  state,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_SIZE*ARRAY_SIZE-1:0]  state_out,
    output logic                             busy,
    output logic                             done
`ifdef ARK_PARITY_EN
    ,
    output logic [ARRAY_SIZE-1:0]            parity_out
`endif
);
    import aes_pkg::*;

    localparam int unsigned STEPS = ARRAY_SIZE / LANES;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned SLICE = WORD_SIZE * LANES;
    localparam int unsigned BW    = WORD_SIZE * ARRAY_SIZE;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    ark_fsm_t          fsm, fsm_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [BW-1:0]     key_q, state_q;
    logic [SLICE-1:0]  key_sl, state_sl, xor_sl;
    logic              accept, last;

    always_comb begin
        in_ready = (fsm == IDLE) || ((fsm == HOLD) && out_ready);
        accept   = in_valid && in_ready;
        last     = (fsm == RUN) && (cnt == CNT_LAST);
        busy     = (fsm == RUN);
        done     = (fsm == HOLD) && out_valid && out_ready;
        key_sl   = key_q[cnt*SLICE +: SLICE];
        state_sl = state_q[cnt*SLICE +: SLICE];
    end

    ark_lane_xor #(
        .WORD_SIZE (WORD_SIZE),
        .LANES     (LANES)
    ) u_lane_xor (
        .key    (key_sl),
        .state  (state_sl),
        .result (xor_sl)
    );

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (accept) fsm_nxt = RUN;
            RUN:     if (last) fsm_nxt = HOLD;
            HOLD:    if (out_ready) fsm_nxt = accept ? RUN : IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fsm <= IDLE;
        else      fsm <= fsm_nxt;
    end

    // Work from captured copies so the source may move on once accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q     <= '0;
            state_q   <= '0;
            state_out <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                key_q   <= key;
                state_q <= state;
            end
            if (fsm == RUN) begin
                state_out[cnt*SLICE +: SLICE] <= xor_sl;
                cnt <= last ? '0 : cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (last)      out_valid <= 1'b1;
            else if (done) out_valid <= 1'b0;
        end
    end

`ifdef ARK_PARITY_EN
    logic [LANES-1:0] lane_par;

    always_comb begin
        lane_par = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_par[i] = ^xor_sl[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            parity_out <= '0;
        else if (fsm == RUN) parity_out[cnt*LANES +: LANES] <= lane_par;
    end
`endif
endmodule

// File: tb/tb_add_round_key_iter.sv
// Self-checking bench for add_round_key_iter: directed FIPS-197 cases plus randomized scoreboard traffic.
module tb_add_round_key_iter;
    localparam int unsigned W  = 8;
    localparam int unsigned N  = 16;
    localparam int unsigned BW = W * N;
    localparam int unsigned NR = 24;
    parameter  int unsigned LANES = 4;
    localparam int unsigned LAT = N / LANES;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [BW-1:0] key, state, state_out;
`ifdef ARK_PARITY_EN
    logic [N-1:0]  parity_out;
`endif

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] fips_st, fips_key, fips_res;

    always #5 clk = ~clk;

    add_round_key_iter #(
        .WORD_SIZE  (W),
        .ARRAY_SIZE (N),
        .LANES      (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key       (key),
        .state     (state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy),
        .done      (done)
`ifdef ARK_PARITY_EN
        ,
        .parity_out(parity_out)
`endif
    );

    // FIPS strings list word 0 first; word 0 lives in the low bits of the bus.
    function automatic logic [BW-1:0] brev(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        for (int i = 0; i < int'(N); i++) r[i*W +: W] = v[(int'(N)-1-i)*W +: W];
        return r;
    endfunction

    function automatic logic [N-1:0] parity_of(input logic [BW-1:0] v);
        logic [N-1:0] p;
        for (int i = 0; i < int'(N); i++) p[i] = ^v[i*W +: W];
        return p;
    endfunction

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; key = '0; state = '0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (state_out !== '0)   begin errors++; $display("FAIL reset_state_out got=%h want=0", state_out); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_fips;
        int lat, busy_cnt;
        lat = -1; busy_cnt = 0;
        @(negedge clk);
        key = fips_key; state = fips_st; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fips_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; key = '0; state = '1;
        for (int k = 0; k <= int'(LAT) + 4; k++) begin
            if (busy) busy_cnt++;
            if (out_valid) begin lat = k; break; end
            @(negedge clk);
        end
        checks++; if (lat != int'(LAT))      begin errors++; $display("FAIL fips_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (busy_cnt != int'(LAT)) begin errors++; $display("FAIL fips_busy_cycles got=%0d want=%0d", busy_cnt, LAT); end
        checks++; if (state_out !== fips_res) begin errors++; $display("FAIL fips_state_out got=%h want=%h", state_out, fips_res); end
        checks++; if (done !== 1'b1)         begin errors++; $display("FAIL fips_done got=%b want=1", done); end
`ifdef ARK_PARITY_EN
        checks++; if (parity_out !== parity_of(fips_res)) begin errors++; $display("FAIL fips_parity got=%h want=%h", parity_out, parity_of(fips_res)); end
        checks++; if (parity_out[1] !== 1'b1) begin errors++; $display("FAIL fips_parity_word1 got=%b want=1", parity_out[1]); end
`endif
        @(negedge clk);
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL fips_done_pulse got=%b want=0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fips_out_valid_clear got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL fips_idle_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_backpressure;
        int lat;
        lat = -1;
        @(negedge clk);
        key = fips_key; state = fips_st; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k <= int'(LAT) + 4; k++) begin
            if (out_valid) begin lat = k; break; end
            @(negedge clk);
        end
        checks++; if (lat != int'(LAT)) begin errors++; $display("FAIL bp_latency got=%0d want=%0d", lat, LAT); end
        for (int c = 0; c < 6; c++) begin
            checks++; if (state_out !== fips_res) begin errors++; $display("FAIL bp_stable got=%h want=%h", state_out, fips_res); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
            checks++; if (done !== 1'b0)      begin errors++; $display("FAIL bp_done_early got=%b want=0", done); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (done !== 1'b1)     begin errors++; $display("FAIL bp_done got=%b want=1", done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_out_valid_clear got=%b want=0", out_valid); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL bp_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_back_to_back;
        int lat;
        lat = -1;
        @(negedge clk);
        key = fips_key; state = fips_st; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        key = '1; state = '0;
        for (int k = 0; k <= int'(LAT) + 4; k++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        checks++; if (state_out !== fips_res) begin errors++; $display("FAIL b2b_first got=%h want=%h", state_out, fips_res); end
        checks++; if (done !== 1'b1)     begin errors++; $display("FAIL b2b_first_done got=%b want=1", done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_same_edge_ready got=%b want=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; key = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble got=%b want=1", busy); end
        for (int k = 0; k <= int'(LAT) + 4; k++) begin
            if (out_valid) begin lat = k; break; end
            @(negedge clk);
        end
        checks++; if (lat != int'(LAT)) begin errors++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (state_out !== {BW{1'b1}}) begin errors++; $display("FAIL b2b_second got=%h want=all ff", state_out); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        key = fips_key; state = fips_st; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (state_out !== '0)   begin errors++; $display("FAIL rmr_state_out got=%h want=0", state_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmr_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rmr_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rmr_done got=%b want=0", done); end
`ifdef ARK_PARITY_EN
        checks++; if (parity_out !== '0)  begin errors++; $display("FAIL rmr_parity got=%h want=0", parity_out); end
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmr_in_ready got=%b want=1", in_ready); end
        for (int k = 0; k < int'(LAT) + 3; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL rmr_spurious out_valid=%b done=%b want=0/0", out_valid, done);
            end
        end
    endtask

    task automatic test_random;
        logic [BW-1:0] q[$];
        logic [BW-1:0] e;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        while (got < int'(NR) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < int'(NR)) && ($urandom_range(0, 2) != 0);
            key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            state = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected_result got=%h want=none", state_out);
                end else begin
                    e = q.pop_front();
                    if (state_out !== e) begin errors++; $display("FAIL rnd_result got=%h want=%h", state_out, e); end
                end
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL rnd_done got=%b want=1", done); end
                got++;
            end else begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL rnd_done_idle got=%b want=0", done); end
            end
            if (in_valid && in_ready) begin
                q.push_back(key ^ state);
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (got != int'(NR)) begin errors++; $display("FAIL rnd_completed got=%0d want=%0d", got, NR); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=hang want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fips_st  = brev(128'h00112233445566778899aabbccddeeff);
        fips_key = brev(128'h000102030405060708090a0b0c0d0e0f);
        fips_res = brev(128'h00102030405060708090a0b0c0d0e0f0);
        test_reset();
        test_fips();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
